// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into instruction words,
// writes them to instruction memory while holding the core in reset, then releases the core.
module imem_boot_loader #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [31:0]       core_addr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                len_ok;
  logic                unused_addr_bits;

  assign len_ok           = (len_words != '0) && (len_words <= DEPTH_L);
  assign unused_addr_bits = ^core_addr[31:ADDR_W+2];

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d    = LOAD;
            len_d      = len_words;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            err_d      = 1'b0;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (rx_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Registered write strobe/address/data are launched by the 4th-byte edge
          if (byte_cnt_q == 2'd3) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_waddr_d = word_cnt_q;
            mem_wdata_d = word_d;
          end
        end
      end
      WRITE: begin
        if ({1'b0, word_cnt_q} == len_q - ONE_L) begin
          state_d      = RUN;
          core_rst_n_d = 1'b1;
          done_d       = 1'b1;
          busy_d       = 1'b0;
        end else begin
          word_cnt_d = word_cnt_q + ADDR_W'(1);
          state_d    = LOAD;
        end
      end
      RUN: begin
        if (start && len_ok) begin
          state_d      = LOAD;
          len_d        = len_words;
          byte_cnt_d   = '0;
          word_cnt_d   = '0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          core_rst_n_d = 1'b0;
        end else if (start || (core_addr[1:0] != 2'b00)) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      word_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_q       <= word_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = (state_q == LOAD);
  assign mem_raddr  = (state_q == RUN) ? core_addr[ADDR_W+1:2] : mem_waddr_q;
  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: write log scoreboard plus hand-computed expectations.
module tb_imem_boot_loader;

  localparam int DEPTH  = 256;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   len_words;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [31:0]       core_addr;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned we_rdy_bad = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  imem_boot_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .core_addr(core_addr), .mem_raddr(mem_raddr), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .core_rst_n(core_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      log_addr.push_back(32'(mem_waddr));
      log_data.push_back(mem_wdata);
      if (rx_ready) we_rdy_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [ADDR_W:0] len);
    start = 1'b1; len_words = len;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    logic ok;
    int unsigned n;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1; rx_data = b;
    n = 0;
    forever begin
      @(negedge clk); ok = rx_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 50) begin
        check("byte_accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned maxgap);
    for (int unsigned j = 0; j < 4; j++) begin
      logic [7:0] b;
      b = w[8*j +: 8];
      send_byte(b, $urandom_range(0, maxgap));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int unsigned bad;
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; len_words = '0;
    rx_valid = 1'b0; rx_data = '0; core_addr = '0;
    #12;
    check_reset_outputs("reset");
    tick(); rst_n = 1'b1; tick();

    // Single word load
    do_start(9'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rx_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    check("t1_we", 32'(mem_we), 32'd1);
    check("t1_waddr", 32'(mem_waddr), 32'd0);
    check("t1_wdata", mem_wdata, 32'h0050_0013);
    check("t1_rdy_in_write", 32'(rx_ready), 32'd0);
    check("t1_core_held", 32'(core_rst_n), 32'd0);
    tick();
    check("t1_we_low", 32'(mem_we), 32'd0);
    check("t1_core_run", 32'(core_rst_n), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_nwrites", 32'(log_addr.size()), 32'd1);

    // Fetch address mapping and misaligned fetch
    core_addr = 32'h0000_0008; #1;
    check("run_raddr", 32'(mem_raddr), 32'd2);
    tick();
    check("run_err_aligned", 32'(err), 32'd0);
    core_addr = 32'h0000_0006; tick();
    check("run_err_misaligned", 32'(err), 32'd1);
    check("run_done_kept", 32'(done), 32'd1);
    core_addr = '0;

    // Reload len=2 from RUN
    log_addr.delete(); log_data.delete();
    do_start(9'd2);
    check("reload_core_rst", 32'(core_rst_n), 32'd0);
    check("reload_done", 32'(done), 32'd0);
    check("reload_err_clr", 32'(err), 32'd0);
    send_word(32'hDEAD_BEEF, 2);
    send_word(32'h1234_5678, 2);
    tick();
    check("reload_done_again", 32'(done), 32'd1);
    check("reload_nwrites", 32'(log_addr.size()), 32'd2);
    check("reload_a0", log_addr[0], 32'd0);
    check("reload_d0", log_data[0], 32'hDEAD_BEEF);
    check("reload_a1", log_addr[1], 32'd1);
    check("reload_d1", log_data[1], 32'h1234_5678);

    // len=3 with irregular rx_valid
    log_addr.delete(); log_data.delete(); we_rdy_bad = 0;
    do_start(9'd3);
    for (int unsigned i = 0; i < 12; i++) send_byte(8'(i + 1), $urandom_range(0, 3));
    tick();
    check("l3_done", 32'(done), 32'd1);
    check("l3_nwrites", 32'(log_addr.size()), 32'd3);
    check("l3_a2", log_addr[2], 32'd2);
    check("l3_d0", log_data[0], 32'h0403_0201);
    check("l3_d1", log_data[1], 32'h0807_0605);
    check("l3_d2", log_data[2], 32'h0C0B_0A09);
    check("l3_rdy_in_write", 32'(we_rdy_bad), 32'd0);

    // Invalid start in RUN
    do_start(9'd0);
    check("run_bad_err", 32'(err), 32'd1);
    check("run_bad_done", 32'(done), 32'd1);
    check("run_bad_core", 32'(core_rst_n), 32'd1);

    // Reset in the middle of a load
    do_start(9'd2);
    for (int unsigned i = 0; i < 6; i++) send_byte(8'hF0 + 8'(i), 0);
    rst_n = 1'b0; #1;
    check_reset_outputs("midrst");
    tick(); rst_n = 1'b1; tick();
    log_addr.delete(); log_data.delete();
    do_start(9'd1);
    send_word(32'hDDCC_BBAA, 0);
    tick();
    check("fresh_nwrites", 32'(log_addr.size()), 32'd1);
    check("fresh_a0", log_addr[0], 32'd0);
    check("fresh_d0", log_data[0], 32'hDDCC_BBAA);

    // Invalid lengths from IDLE
    rst_n = 1'b0; #1; tick(); rst_n = 1'b1; tick();
    do_start(9'd0);
    check("len0_err", 32'(err), 32'd1);
    check("len0_rdy", 32'(rx_ready), 32'd0);
    check("len0_core", 32'(core_rst_n), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    rst_n = 1'b0; #1; tick(); rst_n = 1'b1; tick();
    do_start(9'(DEPTH + 1));
    check("lenbig_err", 32'(err), 32'd1);
    check("lenbig_rdy", 32'(rx_ready), 32'd0);
    check("lenbig_core", 32'(core_rst_n), 32'd0);
    tick();
    check("lenbig_rdy_idle", 32'(rx_ready), 32'd0);

    // Full-depth load clears err and covers every address
    log_addr.delete(); log_data.delete();
    do_start(9'(DEPTH));
    check("full_err_clr", 32'(err), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w = {8'(i + 8'hC3), 8'(i * 3), 8'(~i), 8'(i)};
      send_word(w, 0);
    end
    tick();
    check("full_done", 32'(done), 32'd1);
    check("full_nwrites", 32'(log_addr.size()), 32'(DEPTH));
    bad = 0;
    for (int unsigned i = 0; i < DEPTH && i < log_addr.size(); i++) begin
      w = {8'(i + 8'hC3), 8'(i * 3), 8'(~i), 8'(i)};
      if (log_addr[i] !== 32'(i) || log_data[i] !== w) bad++;
    end
    check("full_contents", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences program load into the word-addressed instruction memory before the core runs.
- Assembles a byte stream (UART/debug side) into little-endian 32-bit words and issues one write pulse per word.
- Holds the core in reset during load, then hands the memory read address over to core fetch.
- Sits between the byte source, the instruction memory write/read ports and the core reset input.

Parameters:
- DEPTH, 256, instruction memory depth in words (power of two, >= 2).
- WIDTH, 32, instruction word width; fixed at 32, four bytes per word.
- ADDR_W, 8, word address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load.
- len_words  in  ADDR_W+1  number of words to load; sampled when start is accepted.
- rx_valid  in  1  byte source has a byte.
- rx_data  in  8  byte value.
- rx_ready  out  1  loader accepts a byte this cycle.
- core_addr  in  32  core fetch byte address.
- mem_raddr  out  ADDR_W  memory read word address.
- mem_we  out  1  memory write strobe.
- mem_waddr  out  ADDR_W  memory write word address.
- mem_wdata  out  WIDTH  memory write data.
- core_rst_n  out  1  active-low reset to the core.
- busy  out  1  load in progress.
- done  out  1  program loaded; core running.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs: rx_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, core_rst_n=0, busy=0, done=0, err=0. Internal byte_cnt=0, word_cnt=0, shift register=0.
- Reset asserted mid-load aborts immediately. Partially written memory contents are left as is; the core stays held in reset.
- States: IDLE, LOAD, WRITE, RUN.
- IDLE: core_rst_n=0.
  - start with 1 <= len_words <= DEPTH -> LOAD, latch len, clear counters, err<=0, busy<=1.
  - start with len_words=0 or > DEPTH -> err<=1 and stay in IDLE.
- LOAD: rx_ready=1 (combinational from state).
  - A byte is accepted when rx_valid && rx_ready.
  - Byte k (byte_cnt=k) goes into word bits [8k+7:8k], so byte 0 lands in the LSB.
  - When the 4th byte is accepted -> WRITE, byte_cnt<=0.
  - start is ignored in LOAD and WRITE.
- WRITE (exactly one cycle): mem_we=1, mem_waddr=word_cnt, mem_wdata=assembled word; rx_ready=0.
  - If word_cnt==len-1 -> RUN. Otherwise word_cnt<=word_cnt+1 and -> LOAD.
- Timing: mem_we is asserted in the cycle immediately after the edge that accepted the 4th byte. Maximum throughput is 4 bytes per 5 cycles.
- RUN: core_rst_n=1, done=1, busy=0, mem_we=0.
  - core_rst_n rises on the edge leaving the final WRITE.
  - mem_raddr=core_addr[ADDR_W+1:2], combinational. Outside RUN, mem_raddr=mem_waddr.
  - A misaligned fetch (core_addr[1:0]!=0) sets err<=1 (sticky). The core keeps running.
  - start in RUN with a valid len: reload. done<=0, core_rst_n<=0 on the next edge, -> LOAD.
  - start in RUN with an invalid len: err<=1, remain in RUN.
- err clears only on reset or on an accepted valid start.
- Wrap-around: word_cnt never exceeds DEPTH-1, because len is bounded at start. len_words=DEPTH writes addresses 0..DEPTH-1.
- All outputs except rx_ready and mem_raddr are registered.

Test Plan:
- Reset then start, len=1, bytes 0x13,0x00,0x50,0x00 -> one mem_we pulse with waddr=0, wdata=0x00500013, the cycle after the 4th byte; core_rst_n=1 and done=1 on the following edge.
- len=3, 12 bytes with rx_valid toggling randomly -> exactly 3 write pulses at waddr 0,1,2 with correct little-endian words; rx_ready=0 during each WRITE cycle; no byte lost or duplicated.
- start with len_words=0, and separately with len_words=DEPTH+1 -> err=1, state IDLE, rx_ready=0, core_rst_n=0. A subsequent valid start clears err.
- In RUN, core_addr=0x0000_0008 -> mem_raddr=2. core_addr=0x0000_0006 -> err=1, done stays 1.
- In RUN, start with len=2 -> core_rst_n=0 and done=0 on the next edge. After 8 bytes, writes go to addresses 0 and 1, then RUN resumes.
- rst_n pulsed low after 6 bytes of a len=2 load -> all outputs go to reset values immediately. A fresh load afterwards starts at waddr=0 with byte_cnt=0.
